// File: rtl/wr_ctrl_prog.sv
// Async FIFO write-side controller: pointer, full/almost_full, level, sticky overflow.
// Define WR_CTRL_OVF_CNT_EN to add the saturating dropped-write counter output ovf_cnt.
module wr_ctrl_prog #(
    parameter int PTR_WIDTH     = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int OVF_CNT_WIDTH = 8
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic [PTR_WIDTH:0]   r_ptr_gray,
    input  logic [PTR_WIDTH:0]   af_thresh,
    input  logic                 ovf_clr,
    output logic                 wr_ack,
    output logic [PTR_WIDTH-1:0] wr_addr,
    output logic [PTR_WIDTH:0]   wr_ptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 overflow
`ifdef WR_CTRL_OVF_CNT_EN
    ,
    output logic [OVF_CNT_WIDTH-1:0] ovf_cnt
`endif
);

    localparam int P = PTR_WIDTH;
    localparam logic [P+1:0] DEPTH = (P+2)'(1) << P;

    logic [P:0]   sync_q [SYNC_STAGES];
    logic [P:0]   rq;
    logic [P:0]   r_bin;
    logic [P:0]   wr_bin_q, wr_bin_d;
    logic [P:0]   gray_q, gray_d;
    logic [P:0]   level_q, level_d;
    logic [P+1:0] free_d;
    logic         full_q, full_d;
    logic         af_q, af_d;
    logic         ovf_q, ovf_d;
    logic         drop;

    assign rq = sync_q[SYNC_STAGES-1];

    always_comb begin
        r_bin = '0;
        for (int i = 0; i <= P; i++) begin
            r_bin[i] = ^(rq >> i);
        end
    end

    assign wr_ack   = wr_en & ~full_q;
    assign drop     = wr_en & full_q;
    assign wr_bin_d = wr_bin_q + {{P{1'b0}}, wr_ack};
    assign gray_d   = wr_bin_d ^ (wr_bin_d >> 1);
    // Full when the write pointer is one lap ahead of the synchronised read pointer
    assign full_d   = (gray_d == {~rq[P:P-1], rq[P-2:0]});
    assign level_d  = wr_bin_d - r_bin;
    assign free_d   = DEPTH - {1'b0, level_d};
    assign af_d     = (free_d <= {1'b0, af_thresh});
    assign ovf_d    = drop | (ovf_q & ~ovf_clr);

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= r_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_bin_q <= '0;
            gray_q   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_bin_q <= wr_bin_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_addr     = wr_bin_q[P-1:0];
    assign wr_ptr_gray = gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

`ifdef WR_CTRL_OVF_CNT_EN
    logic [OVF_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // A drop coinciding with a clear leaves a count of one
    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clr) begin
            cnt_d = {{(OVF_CNT_WIDTH-1){1'b0}}, drop};
        end else if (drop && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovf_cnt = cnt_q;
`else
    logic unused_cfg;
    assign unused_cfg = (OVF_CNT_WIDTH != 0);
`endif

endmodule
